// File: rtl/core_periph_arbiter.sv
// Round-robin arbiter between the core data port (m0) and the debug/DMA port (m1) for the shared
// peripheral bus: a registered payload, one-cycle completion pulses, and a timeout error completion.
module core_periph_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              m0_valid,
    input  logic              m0_write,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ready,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,
    input  logic              m1_valid,
    input  logic              m1_write,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,
    output logic              p_req,
    output logic              p_write,
    output logic [ADDR_W-1:0] p_addr,
    output logic [DATA_W-1:0] p_wdata,
    input  logic              p_ack,
    input  logic [DATA_W-1:0] p_rdata,
    output logic              busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    logic [1:0]        state_q, state_d;
    logic              grant_q, grant_d;   // 0 = m0, 1 = m1
    logic              last_q, last_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic              p_write_q, p_write_d;
    logic [ADDR_W-1:0] p_addr_q, p_addr_d;
    logic [DATA_W-1:0] p_wdata_q, p_wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        p_write_d = p_write_q;
        p_addr_d  = p_addr_q;
        p_wdata_d = p_wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE: begin
                if (m0_valid || m1_valid) begin
                    // On a tie the requester that was not served last wins.
                    grant_d   = (m0_valid && m1_valid) ? ~last_q : m1_valid;
                    p_write_d = grant_d ? m1_write : m0_write;
                    p_addr_d  = grant_d ? m1_addr  : m0_addr;
                    p_wdata_d = grant_d ? m1_wdata : m0_wdata;
                    cnt_d     = '0;
                    state_d   = S_BUSY;
                end
            end
            S_BUSY: begin
                if (p_ack) begin
                    rdata_d = p_write_q ? '0 : p_rdata;
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else if (cnt_q == TO_LAST) begin
                    rdata_d = '1;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            S_DONE: begin
                last_d  = grant_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            grant_q   <= 1'b0;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            p_write_q <= 1'b0;
            p_addr_q  <= '0;
            p_wdata_q <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            p_write_q <= p_write_d;
            p_addr_q  <= p_addr_d;
            p_wdata_q <= p_wdata_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    // Handshake outputs decode straight from state so an async reset clears them at once.
    assign p_req    = (state_q == S_BUSY);
    assign busy     = (state_q != S_IDLE);
    assign p_write  = p_write_q;
    assign p_addr   = p_addr_q;
    assign p_wdata  = p_wdata_q;
    assign m0_ready = (state_q == S_DONE) && !grant_q;
    assign m1_ready = (state_q == S_DONE) &&  grant_q;
    assign m0_rdata = m0_ready ? rdata_q : '0;
    assign m1_rdata = m1_ready ? rdata_q : '0;
    assign m0_err   = m0_ready && err_q;
    assign m1_err   = m1_ready && err_q;

endmodule
